// File: rtl/latch_write_sequencer_pkg.sv
// Shared types and elaboration helpers for the latch write sequencer.
// Holds the FSM state encoding, address-width derivation and phase-length checks.
package latch_write_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD,
      ST_CLEAR
   } state_t;

   function automatic int aw_of(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   function automatic bit phases_ok(input int s, input int e, input int h, input int c);
      return (s >= 1) && (e >= 1) && (h >= 1) && (c >= 1);
   endfunction

endpackage

// File: rtl/latch_write_sequencer_phase_counter.sv
// Loadable down-counter used to time each FSM phase; tc flags a count of zero.
module latch_phase_counter #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         srst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tc
);

   logic [W-1:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (srst) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= load_val;
      end else if (cnt_reg != '0) begin
         cnt_reg <= cnt_reg - 1'b1;
      end
   end

   assign tc = (cnt_reg == '0);

endmodule

// File: rtl/latch_write_sequencer.sv
// Write/clear sequencer producing registered LD/LE/LRN controls for a latch bank.
// Every output is a register fed from next-state logic, so the latch controls never glitch.
module latch_write_sequencer
   import latch_write_sequencer_pkg::*;
#(
   parameter int DW      = 8,
   parameter int NLAT    = 5,
   parameter int SETUP   = 1,
   parameter int E_HIGH  = 2,
   parameter int HOLD    = 1,
   parameter int CLR_CYC = 2,
   localparam int AW     = aw_of(NLAT)
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            REQ_VALID,
   output logic            REQ_READY,
   input  logic [AW-1:0]   REQ_ADDR,
   input  logic [DW-1:0]   REQ_DATA,
   input  logic            CLR_REQ,
   output logic [DW-1:0]   LD,
   output logic [NLAT-1:0] LE,
   output logic            LRN,
   output logic            DONE,
   output logic            ERR
);

   localparam int CW = aw_of(max4(SETUP, E_HIGH, HOLD, CLR_CYC));
   localparam logic [CW-1:0] L_SETUP = CW'(SETUP - 1);
   localparam logic [CW-1:0] L_EHIGH = CW'(E_HIGH - 1);
   localparam logic [CW-1:0] L_HOLD  = CW'(HOLD - 1);
   localparam logic [CW-1:0] L_CLR   = CW'(CLR_CYC - 1);
   localparam logic [AW:0]   NLAT_W  = (AW + 1)'(NLAT);

   if (!phases_ok(SETUP, E_HIGH, HOLD, CLR_CYC) || NLAT < 1) begin : g_bad_params
      $error("latch_write_sequencer: phase lengths and NLAT must all be >= 1");
   end

   state_t            state_reg, state_next;
   logic [AW-1:0]     addr_reg, addr_next;
   logic [DW-1:0]     ld_reg, ld_next;
   logic [NLAT-1:0]   le_reg, le_next;
   logic              lrn_reg, lrn_next;
   logic              ready_reg, ready_next;
   logic              done_reg, done_next;
   logic              err_reg, err_next;
   // boot: reset-entry clear still has to prime the counter; quiet: that clear ends without DONE.
   logic              boot_reg, boot_next;
   logic              quiet_reg, quiet_next;
   logic              cnt_load;
   logic [CW-1:0]     cnt_val;
   logic              cnt_tc;
   logic              addr_ok;
   logic [NLAT-1:0]   dec;

   latch_phase_counter #(.W(CW)) u_phase_counter (
      .clk      (CLK),
      .srst     (RST),
      .load     (cnt_load),
      .load_val (cnt_val),
      .tc       (cnt_tc)
   );

   assign addr_ok = ({1'b0, addr_reg} < NLAT_W);

   for (genvar gi = 0; gi < NLAT; gi++) begin : g_dec
      assign dec[gi] = (addr_reg == AW'(gi));
   end

   always_comb begin
      state_next = state_reg;
      addr_next  = addr_reg;
      ld_next    = ld_reg;
      done_next  = 1'b0;
      err_next   = 1'b0;
      boot_next  = boot_reg;
      quiet_next = quiet_reg;
      cnt_load   = 1'b0;
      cnt_val    = '0;
      case (state_reg)
         ST_IDLE: begin
            if (CLR_REQ) begin
               state_next = ST_CLEAR;
               cnt_load   = 1'b1;
               cnt_val    = L_CLR;
            end else if (REQ_VALID) begin
               state_next = ST_SETUP;
               cnt_load   = 1'b1;
               cnt_val    = L_SETUP;
               addr_next  = REQ_ADDR;
               ld_next    = REQ_DATA;
            end
         end
         ST_SETUP: begin
            if (cnt_tc) begin
               state_next = ST_PULSE;
               cnt_load   = 1'b1;
               cnt_val    = L_EHIGH;
            end
         end
         ST_PULSE: begin
            if (cnt_tc) begin
               state_next = ST_HOLD;
               cnt_load   = 1'b1;
               cnt_val    = L_HOLD;
            end
         end
         ST_HOLD: begin
            if (cnt_tc) begin
               state_next = ST_IDLE;
               done_next  = 1'b1;
               err_next   = !addr_ok;
            end
         end
         ST_CLEAR: begin
            if (boot_reg) begin
               cnt_load  = 1'b1;
               cnt_val   = L_CLR;
               boot_next = 1'b0;
            end else if (cnt_tc) begin
               state_next = ST_IDLE;
               done_next  = !quiet_reg;
               quiet_next = 1'b0;
            end
         end
         default: state_next = ST_CLEAR;
      endcase
      ready_next = (state_next == ST_IDLE);
      lrn_next   = (state_next != ST_CLEAR);
      le_next    = (state_next == ST_PULSE) ? dec : '0;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg <= ST_CLEAR;
         addr_reg  <= '0;
         ld_reg    <= '0;
         le_reg    <= '0;
         lrn_reg   <= 1'b0;
         ready_reg <= 1'b0;
         done_reg  <= 1'b0;
         err_reg   <= 1'b0;
         boot_reg  <= 1'b1;
         quiet_reg <= 1'b1;
      end else begin
         state_reg <= state_next;
         addr_reg  <= addr_next;
         ld_reg    <= ld_next;
         le_reg    <= le_next;
         lrn_reg   <= lrn_next;
         ready_reg <= ready_next;
         done_reg  <= done_next;
         err_reg   <= err_next;
         boot_reg  <= boot_next;
         quiet_reg <= quiet_next;
      end
   end

   assign LD        = ld_reg;
   assign LE        = le_reg;
   assign LRN       = lrn_reg;
   assign REQ_READY = ready_reg;
   assign DONE      = done_reg;
   assign ERR       = err_reg;

endmodule

// File: tb/tb_latch_write_sequencer.sv
// Directed bench for latch_write_sequencer with default parameters.
module tb_latch_write_sequencer;

   localparam int DW = 8;
   localparam int NLAT = 5;
   localparam int AW = 3;

   logic            CLK = 1'b0;
   logic            RST = 1'b1;
   logic            REQ_VALID = 1'b0;
   logic            REQ_READY;
   logic [AW-1:0]   REQ_ADDR = '0;
   logic [DW-1:0]   REQ_DATA = '0;
   logic            CLR_REQ = 1'b0;
   logic [DW-1:0]   LD;
   logic [NLAT-1:0] LE;
   logic            LRN;
   logic            DONE;
   logic            ERR;

   int tests = 0;
   int fails = 0;

   latch_write_sequencer dut (
      .CLK       (CLK),
      .RST       (RST),
      .REQ_VALID (REQ_VALID),
      .REQ_READY (REQ_READY),
      .REQ_ADDR  (REQ_ADDR),
      .REQ_DATA  (REQ_DATA),
      .CLR_REQ   (CLR_REQ),
      .LD        (LD),
      .LE        (LE),
      .LRN       (LRN),
      .DONE      (DONE),
      .ERR       (ERR)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Release sequence after RST falls: LRN/READY/DONE expected at edges 1..4.
   task automatic release_seq(input string tag);
      logic exp_lrn [1:4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      RST = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         tick();
         tests++;
         if (LRN !== exp_lrn[e] || REQ_READY !== exp_lrn[e] || DONE !== 1'b0 || LE !== '0) begin
            fails++;
            $display("FAIL %s_release edge%0d: LRN=%b READY=%b DONE=%b LE=%b required LRN=%b READY=%b DONE=0 LE=0",
                     tag, e, LRN, REQ_READY, DONE, LE, exp_lrn[e], exp_lrn[e]);
         end
      end
      $display("[TB] %s release sequence checked", tag);
   endtask

   task automatic test_reset();
      RST = 1'b1;
      for (int e = 1; e <= 3; e++) begin
         tick();
         tests++;
         if (LE !== '0 || LD !== '0 || LRN !== 1'b0 || REQ_READY !== 1'b0 || DONE !== 1'b0 || ERR !== 1'b0) begin
            fails++;
            $display("FAIL reset_state cyc%0d: LE=%b LD=%h LRN=%b READY=%b DONE=%b ERR=%b required all 0",
                     e, LE, LD, LRN, REQ_READY, DONE, ERR);
         end
      end
      release_seq("reset");
   endtask

   task automatic test_single_write();
      logic [NLAT-1:0] exp_le [1:6] = '{5'b0, 5'b01000, 5'b01000, 5'b0, 5'b0, 5'b0};
      logic            exp_done [1:6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      REQ_VALID = 1'b1; REQ_ADDR = 3'd3; REQ_DATA = 8'hA5;
      for (int e = 1; e <= 6; e++) begin
         tick();
         REQ_VALID = 1'b0;
         tests++;
         if (LE !== exp_le[e] || LD !== 8'hA5 || DONE !== exp_done[e] || ERR !== 1'b0 ||
             REQ_READY !== (e >= 5) || LRN !== 1'b1) begin
            fails++;
            $display("FAIL single_write edge%0d: LE=%b LD=%h DONE=%b ERR=%b READY=%b LRN=%b required LE=%b LD=a5 DONE=%b ERR=0 READY=%b LRN=1",
                     e, LE, LD, DONE, ERR, REQ_READY, LRN, exp_le[e], exp_done[e], e >= 5);
         end
      end
      $display("[TB] single write addr=3 data=a5 checked");
   endtask

   task automatic test_back_to_back();
      logic [NLAT-1:0] exp_le [1:11] = '{5'b0, 5'b00001, 5'b00001, 5'b0, 5'b0, 5'b0,
                                         5'b10000, 5'b10000, 5'b0, 5'b0, 5'b0};
      logic [DW-1:0]   exp_ld [1:11] = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22,
                                         8'h22, 8'h22, 8'h22, 8'h22, 8'h22};
      logic            exp_done [1:11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                           1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      REQ_VALID = 1'b1; REQ_ADDR = 3'd0; REQ_DATA = 8'h11;
      for (int e = 1; e <= 11; e++) begin
         tick();
         if (e == 1) begin REQ_ADDR = 3'd4; REQ_DATA = 8'h22; end
         if (e == 6) REQ_VALID = 1'b0;
         tests++;
         if (LE !== exp_le[e] || LD !== exp_ld[e] || DONE !== exp_done[e] || $countones(LE) > 1) begin
            fails++;
            $display("FAIL back_to_back edge%0d: LE=%b LD=%h DONE=%b required LE=%b LD=%h DONE=%b",
                     e, LE, LD, DONE, exp_le[e], exp_ld[e], exp_done[e]);
         end
      end
      $display("[TB] back-to-back writes addr=0/4 checked");
   endtask

   task automatic test_priority();
      logic exp_lrn [1:4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic exp_rdy [1:4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic exp_done [1:4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      CLR_REQ = 1'b1; REQ_VALID = 1'b1; REQ_ADDR = 3'd1; REQ_DATA = 8'h5A;
      for (int e = 1; e <= 4; e++) begin
         tick();
         CLR_REQ = 1'b0; REQ_VALID = 1'b0;
         tests++;
         if (LRN !== exp_lrn[e] || REQ_READY !== exp_rdy[e] || DONE !== exp_done[e] ||
             LE !== '0 || LD !== 8'h22 || ERR !== 1'b0) begin
            fails++;
            $display("FAIL clr_priority edge%0d: LRN=%b READY=%b DONE=%b LE=%b LD=%h ERR=%b required LRN=%b READY=%b DONE=%b LE=0 LD=22 ERR=0",
                     e, LRN, REQ_READY, DONE, LE, LD, ERR, exp_lrn[e], exp_rdy[e], exp_done[e]);
         end
      end
      $display("[TB] clear priority over write checked");
   endtask

   task automatic test_out_of_range();
      logic [AW-1:0] addrs [0:1] = '{3'd5, 3'd6};
      for (int k = 0; k < 2; k++) begin
         REQ_VALID = 1'b1; REQ_ADDR = addrs[k]; REQ_DATA = 8'h3C + 8'(k);
         for (int e = 1; e <= 6; e++) begin
            tick();
            REQ_VALID = 1'b0;
            tests++;
            if (LE !== '0 || LD !== 8'h3C + 8'(k) || DONE !== (e == 5) || ERR !== (e == 5)) begin
               fails++;
               $display("FAIL out_of_range addr=%0d edge%0d: LE=%b LD=%h DONE=%b ERR=%b required LE=0 LD=%h DONE=%b ERR=%b",
                        addrs[k], e, LE, LD, DONE, ERR, 8'h3C + 8'(k), e == 5, e == 5);
            end
         end
         $display("[TB] out-of-range addr=%0d checked", addrs[k]);
      end
   endtask

   task automatic test_mid_reset();
      REQ_VALID = 1'b1; REQ_ADDR = 3'd2; REQ_DATA = 8'h77;
      tick();
      REQ_VALID = 1'b0;
      tick();
      tests++;
      if (LE !== 5'b00100 || LD !== 8'h77) begin
         fails++;
         $display("FAIL mid_reset_pulse: LE=%b LD=%h required LE=00100 LD=77", LE, LD);
      end
      RST = 1'b1;
      tick();
      tests++;
      if (LE !== '0 || LD !== '0 || LRN !== 1'b0 || REQ_READY !== 1'b0 || DONE !== 1'b0) begin
         fails++;
         $display("FAIL mid_reset_apply: LE=%b LD=%h LRN=%b READY=%b DONE=%b required all 0",
                  LE, LD, LRN, REQ_READY, DONE);
      end
      release_seq("mid");
      tick();
      tests++;
      if (DONE !== 1'b0 || LE !== '0) begin
         fails++;
         $display("FAIL mid_reset_discard: DONE=%b LE=%b required DONE=0 LE=0", DONE, LE);
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_back_to_back();
      test_priority();
      test_out_of_range();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
